// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//   bp_state_e   : controller states (INIT sweep, RUN)
//   bp_idx_w     : index width for a table depth
//   ctr_sat_inc  : saturating increment of a CTR_BITS-wide counter (bits 2..4)
//   ctr_sat_dec  : saturating decrement, floor 0
package bp_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;

  function automatic int unsigned bp_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Counters are carried in a 4-bit container; bits selects the live width.
  function automatic logic [3:0] ctr_sat_inc(input logic [3:0] c, input int unsigned bits);
    logic [3:0] mx;
    mx = 4'((1 << bits) - 1);
    return (c >= mx) ? mx : c + 4'd1;
  endfunction

  function automatic logic [3:0] ctr_sat_dec(input logic [3:0] c, input int unsigned bits);
    logic [3:0] unused_bits;
    unused_bits = 4'(bits);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// bp_table: BTB storage (valid, tag, target[XLEN-1:2], counter per entry).
//   i_rd0_* : lookup read port (combinational)
//   i_rd1_* : update read port (combinational, feeds the update policy)
//   i_wr_*  : write port, sets valid and overwrites tag/target/counter
//   i_clr_* : clear port used by the init sweep, drops valid only
// Only valid is ever cleared; tag/target/counter are don't-care while invalid.
module bp_table import bp_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int IDX      = bp_idx_w(ENTRIES)
) (
  input  logic                clk,
  input  logic [IDX-1:0]      i_rd0_idx,
  output logic                o_rd0_valid,
  output logic [TAG_BITS-1:0] o_rd0_tag,
  output logic [XLEN-3:0]     o_rd0_tgt,
  output logic [CTR_BITS-1:0] o_rd0_ctr,
  input  logic [IDX-1:0]      i_rd1_idx,
  output logic                o_rd1_valid,
  output logic [TAG_BITS-1:0] o_rd1_tag,
  output logic [XLEN-3:0]     o_rd1_tgt,
  output logic [CTR_BITS-1:0] o_rd1_ctr,
  input  logic                i_wr_en,
  input  logic [IDX-1:0]      i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic [XLEN-3:0]     i_wr_tgt,
  input  logic [CTR_BITS-1:0] i_wr_ctr,
  input  logic                i_clr_en,
  input  logic [IDX-1:0]      i_clr_idx
);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag [ENTRIES];
  logic [XLEN-3:0]     r_tgt [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr [ENTRIES];

  // Clear and write never overlap (sweep only in INIT, writes only in RUN);
  // clear wins anyway so the sweep is authoritative.
  always_ff @(posedge clk) begin
    if (i_clr_en)     r_valid[i_clr_idx] <= 1'b0;
    else if (i_wr_en) r_valid[i_wr_idx]  <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_tgt[i_wr_idx] <= i_wr_tgt;
      r_ctr[i_wr_idx] <= i_wr_ctr;
    end
  end

  assign o_rd0_valid = r_valid[i_rd0_idx];
  assign o_rd0_tag   = r_tag[i_rd0_idx];
  assign o_rd0_tgt   = r_tgt[i_rd0_idx];
  assign o_rd0_ctr   = r_ctr[i_rd0_idx];
  assign o_rd1_valid = r_valid[i_rd1_idx];
  assign o_rd1_tag   = r_tag[i_rd1_idx];
  assign o_rd1_tgt   = r_tgt[i_rd1_idx];
  assign o_rd1_ctr   = r_ctr[i_rd1_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: dynamic BTB + saturating-counter predictor for IF.
//   clk, rst_n (sync, active-HIGH despite the name), enable
//   if_pc -> pred_hit / pred_taken / pred_target  (combinational lookup)
//   upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict : EX resolution
//   ready : init sweep finished
// Optional macro BP_STATS_EN adds stat_lookups/stat_updates/stat_mispredicts.
module branch_predictor import bp_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
`ifdef BP_STATS_EN
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            ready
);

  localparam int IDX = bp_idx_w(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1 << (CTR_BITS - 1));

  bp_state_e           r_state, w_state_nxt;
  logic [IDX-1:0]      r_sweep_idx, w_sweep_nxt;
  logic                w_clr_en, w_run;

  logic [IDX-1:0]      w_lk_idx, w_up_idx;
  logic [TAG_BITS-1:0] w_lk_tag, w_up_tag, w_lk_tag_q, w_up_tag_q;
  logic                w_lk_valid, w_up_valid;
  logic [XLEN-3:0]     w_lk_tgt, w_up_tgt, w_wr_tgt;
  logic [CTR_BITS-1:0] w_lk_ctr, w_up_ctr, w_wr_ctr;
  logic                w_wr_en, w_upd_acc, w_up_hit;

  // ---- controller ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    w_clr_en    = 1'b0;
    case (r_state)
      INIT: if (enable) begin
        w_clr_en = 1'b1;
        if (r_sweep_idx == IDX'(ENTRIES - 1)) begin
          w_state_nxt = RUN;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_idx + IDX'(1);
        end
      end
      RUN: ;
    endcase
  end

  assign w_run = (r_state == RUN);
  assign ready = w_run;

  // ---- lookup (zero latency, no bypass from a same-cycle update) ----
  assign w_lk_idx    = if_pc[IDX+1:2];
  assign w_lk_tag    = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign pred_hit    = w_run & w_lk_valid & (w_lk_tag_q == w_lk_tag);
  assign pred_taken  = enable & pred_hit & w_lk_ctr[CTR_BITS-1];
  assign pred_target = pred_taken ? {w_lk_tgt, 2'b00} : if_pc + XLEN'(4);

  // ---- update policy ----
  assign w_up_idx  = upd_pc[IDX+1:2];
  assign w_up_tag  = upd_pc[IDX+TAG_BITS+1:IDX+2];
  assign w_upd_acc = w_run & enable & upd_valid;
  assign w_up_hit  = w_up_valid & (w_up_tag_q == w_up_tag);

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_tgt = upd_target[XLEN-1:2];
    w_wr_ctr = CTR_WEAK_T;
    if (w_upd_acc) begin
      if (w_up_hit) begin
        w_wr_en = 1'b1;
        if (upd_taken) begin
          w_wr_ctr = CTR_BITS'(ctr_sat_inc(4'(w_up_ctr), CTR_BITS));
        end else begin
          // Not-taken keeps the entry (even at 0) and its last target.
          w_wr_ctr = CTR_BITS'(ctr_sat_dec(4'(w_up_ctr), CTR_BITS));
          w_wr_tgt = w_up_tgt;
        end
      end else if (upd_taken) begin
        w_wr_en = 1'b1;   // allocate / replace the aliased entry
      end
    end
  end

  bp_table #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS), .IDX(IDX)
  ) u_table (
    .clk        (clk),
    .i_rd0_idx  (w_lk_idx),
    .o_rd0_valid(w_lk_valid),
    .o_rd0_tag  (w_lk_tag_q),
    .o_rd0_tgt  (w_lk_tgt),
    .o_rd0_ctr  (w_lk_ctr),
    .i_rd1_idx  (w_up_idx),
    .o_rd1_valid(w_up_valid),
    .o_rd1_tag  (w_up_tag_q),
    .o_rd1_tgt  (w_up_tgt),
    .o_rd1_ctr  (w_up_ctr),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_up_idx),
    .i_wr_tag   (w_up_tag),
    .i_wr_tgt   (w_wr_tgt),
    .i_wr_ctr   (w_wr_ctr),
    .i_clr_en   (w_clr_en),
    .i_clr_idx  (r_sweep_idx)
  );

`ifdef BP_STATS_EN
  logic [31:0] r_stat_lk, r_stat_up, r_stat_mp;
  logic        w_unused;
  assign w_unused = ^{upd_pc, upd_target[1:0]};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_stat_lk <= '0;
      r_stat_up <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_run && enable && r_stat_lk != '1) r_stat_lk <= r_stat_lk + 32'd1;
      if (w_upd_acc && r_stat_up != '1)       r_stat_up <= r_stat_up + 32'd1;
      if (w_upd_acc && upd_mispredict && r_stat_mp != '1) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_lookups     = r_stat_lk;
  assign stat_updates     = r_stat_up;
  assign stat_mispredicts = r_stat_mp;
`else
  logic w_unused;
  assign w_unused = ^{upd_pc, upd_target[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk, rst_n, enable;
  logic [31:0] if_pc, upd_pc, upd_target, pred_target;
  logic        pred_hit, pred_taken, upd_valid, upd_taken, upd_mispredict, ready;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_updates, stat_mispredicts;
`endif

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
`ifdef BP_STATS_EN
    .stat_lookups(stat_lookups), .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts),
`endif
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, uv;
    logic [31:0] up;
    logic        ut;
    logic [31:0] utg;
    logic        mp;
    logic [31:0] pc;
    logic        eh, et;
    logic [31:0] etg;
  } vec_t;

  typedef struct {
    logic        hit, taken, rdy;
    logic [31:0] tgt;
    string       nm;
  } exp_t;

  vec_t vt [24];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = sb.pop_front();
    n_chk++;
    if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt || ready !== e.rdy) begin
      n_fail++;
      $display("FAIL %s: got hit=%0b taken=%0b tgt=%h ready=%0b, want hit=%0b taken=%0b tgt=%h ready=%0b",
               e.nm, pred_hit, pred_taken, pred_target, ready, e.hit, e.taken, e.tgt, e.rdy);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
    end
  endtask

  // One cycle: drive inputs after the edge, queue the expectation, compare
  // at the falling edge, then let the rising edge commit any update.
  task automatic cyc(input logic en, input logic uv, input logic [31:0] up, input logic ut,
                     input logic [31:0] utg, input logic mp, input logic [31:0] pc,
                     input logic eh, input logic et, input logic [31:0] etg,
                     input logic er, input string nm);
    exp_t e;
    enable = en; upd_valid = uv; upd_pc = up; upd_taken = ut;
    upd_target = utg; upd_mispredict = mp; if_pc = pc;
    e.hit = eh; e.taken = et; e.tgt = etg; e.rdy = er; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_r;
    //            en    uv    upd_pc     ut    upd_tgt    mp    if_pc      hit   tk    exp_tgt
    vt[0]  = '{1'b1, 1'b1, 32'h040, 1'b1, 32'h100, 1'b0, 32'h040, 1'b0, 1'b0, 32'h044}; // same-cycle: old entry
    vt[1]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b1, 32'h100};
    vt[2]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h044, 1'b0, 1'b0, 32'h048};
    vt[3]  = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b1, 32'h100}; // ctr 2->1
    vt[4]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044};
    vt[5]  = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044}; // 1->0
    vt[6]  = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044}; // stays 0
    vt[7]  = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044}; // stays 0
    vt[8]  = '{1'b1, 1'b1, 32'h040, 1'b1, 32'h200, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044}; // 0->1
    vt[9]  = '{1'b1, 1'b1, 32'h040, 1'b1, 32'h204, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044}; // 1->2
    vt[10] = '{1'b1, 1'b1, 32'h040, 1'b1, 32'h208, 1'b0, 32'h040, 1'b1, 1'b1, 32'h204}; // 2->3
    vt[11] = '{1'b1, 1'b1, 32'h040, 1'b1, 32'h20c, 1'b0, 32'h040, 1'b1, 1'b1, 32'h208}; // 3 sat
    vt[12] = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b1, 32'h20c}; // 3->2
    vt[13] = '{1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b1, 32'h20c}; // 2->1
    vt[14] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 1'b0, 32'h044};
    vt[15] = '{1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h140, 1'b0, 1'b0, 32'h144}; // alias replaces
    vt[16] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 32'h044};
    vt[17] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h140, 1'b1, 1'b1, 32'h300};
    vt[18] = '{1'b1, 1'b1, 32'h080, 1'b1, 32'h403, 1'b0, 32'h080, 1'b0, 1'b0, 32'h084}; // low bits dropped
    vt[19] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h080, 1'b1, 1'b1, 32'h400};
    vt[20] = '{1'b1, 1'b1, 32'h0c0, 1'b0, 32'h000, 1'b0, 32'h0c0, 1'b0, 1'b0, 32'h0c4}; // miss NT: no alloc
    vt[21] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h0c0, 1'b0, 1'b0, 32'h0c4};
    vt[22] = '{1'b0, 1'b1, 32'h080, 1'b0, 32'h000, 1'b0, 32'h080, 1'b1, 1'b0, 32'h084}; // enable=0
    vt[23] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h080, 1'b1, 1'b1, 32'h400}; // update ignored

    rst_n = 1'b1; enable = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Sweep: exactly 64 not-ready cycles, every lookup falls through.
    for (int i = 0; i < 64; i++) begin
      pc_r = 32'($urandom_range(0, 32'hFFFF)) << 2;
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, pc_r, 1'b0, 1'b0, pc_r + 32'd4, 1'b0, "sweep");
    end

    for (int i = 0; i < 24; i++)
      cyc(vt[i].en, vt[i].uv, vt[i].up, vt[i].ut, vt[i].utg, vt[i].mp, vt[i].pc,
          vt[i].eh, vt[i].et, vt[i].etg, 1'b1, $sformatf("vec%0d", i));

    // Reset during an update: lookup this cycle still sees RUN state.
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 32'h040, 1'b1, 32'h500, 1'b0, 32'h140, 1'b1, 1'b1, 32'h300, 1'b1, "rst_mid_upd");
    rst_n = 1'b0;
    // Stale valid entries must not predict during INIT.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h140, 1'b0, 1'b0, 32'h144, 1'b0, "init_gate");
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h140, 1'b0, 1'b0, 32'h144, 1'b0, "sweep_frozen");
    for (int i = 0; i < 54; i++)
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h140, 1'b0, 1'b0, 32'h144, 1'b0, "sweep_tail");
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h140, 1'b0, 1'b0, 32'h144, 1'b1, "post_sweep_cleared");
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h040, 1'b0, 1'b0, 32'h044, 1'b1, "discarded_upd");

`ifdef BP_STATS_EN
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000, (i < 3), 32'h0,
          1'b0, 1'b0, 32'h4, 1'b1, "stats_upd");
    upd_valid = 1'b0;
    @(negedge clk);
    chk32("stat_updates", stat_updates, 32'd10);
    chk32("stat_mispredicts", stat_mispredicts, 32'd3);
    chk32("stat_lookups", stat_lookups, 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor (branch target buffer plus per-entry saturating counters) for the 5-stage MIPS pipeline.
- Looked up combinationally in IF with the current PC. Updated from EX when a branch or jump resolves.
- Successor to the fixed static "predict not-taken plus flush" scheme. Reduces IF/ID flushes on taken branches.
- Tables are cleared by a sequential sweep after reset.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, table depth. Must be a power of 2, minimum 4.
- TAG_BITS, 8, PC tag bits stored per entry.
- CTR_BITS, 2, width of the saturating direction counter (2..4).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset. Synchronous, active-high: asserted=1 resets, despite the port name.
- enable  in  1  global enable. When 0: no updates, no sweep progress, pred_taken forced 0.
- if_pc  in  XLEN  PC of the instruction being fetched.
- pred_hit  out  1  tag match on a valid entry.
- pred_taken  out  1  predict taken (hit and counter MSB=1).
- pred_target  out  XLEN  predicted target. Valid only when pred_taken=1; otherwise PC+4.
- upd_valid  in  1  a branch/jump resolved in EX this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target.
- upd_mispredict  in  1  pipeline flushed due to this resolution.
- ready  out  1  1 once the init sweep is complete.

Behaviour:
- Index = PC[IDX+1:2], where IDX = log2(ENTRIES). Tag = PC[IDX+TAG_BITS+1:IDX+2].
- Entry contents: valid, tag, target[XLEN-1:2], ctr[CTR_BITS-1:0].
- FSM states: INIT, RUN.
  - rst_n=1 (any state, including mid-sweep or mid-update) → INIT, sweep index=0, ready=0.
  - INIT: each enabled cycle clears valid[index] and increments index. When index = ENTRIES-1 the entry is cleared and the FSM goes to RUN. A sweep takes exactly ENTRIES enabled cycles.
  - RUN: ready=1. Normal operation.
- Outputs during INIT: pred_hit=0, pred_taken=0, pred_target=if_pc+4. Updates are ignored.
- Reset values: ready=0, pred_hit=0, pred_taken=0. All stat counters are 0.
- Lookup is purely combinational from if_pc, i.e. zero-cycle latency into the IF PC mux.
  - pred_target = {target, 2'b00} on a taken prediction; otherwise if_pc+4.
- Update takes effect on the clock edge. It is visible to a lookup on the following cycle.
- Same-cycle lookup and update of the same index: the lookup sees the old entry. There is no bypass.
- Update rules (RUN, enable=1, upd_valid=1):
  - Hit, taken: ctr saturating +1 (max 2^CTR_BITS-1). Target overwritten with upd_target.
  - Hit, not taken: ctr saturating −1 (min 0). Target unchanged. The entry stays valid at ctr=0.
  - Miss, taken: allocate/replace at the index. valid=1, new tag, target=upd_target, ctr=weakly-taken (2^(CTR_BITS-1)).
  - Miss, not taken: no change.
- upd_target low two bits are ignored.
- Counter arithmetic must never wrap. Saturation at both ends is mandatory.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds outputs stat_lookups[31:0], stat_updates[31:0] and stat_mispredicts[31:0].
  - stat_lookups increments on each RUN cycle with enable=1.
  - stat_updates increments on each accepted update.
  - stat_mispredicts increments on each accepted update with upd_mispredict=1.
  - All three saturate at 2^32−1 and clear on reset.
- When undefined: the ports are absent, no counter logic exists, and upd_mispredict is unused.

Decomposition:
- Package bp_pkg holds:
  - typedef bp_state_e {INIT, RUN};
  - function ctr_sat_inc/ctr_sat_dec (parametrised via CTR_BITS argument);
  - localparam helper for the index width (clog2).
- One natural sub-module: bp_table. It contains the storage arrays, the combinational read port, the write port, and the clear port used by the sweep.
- The FSM, lookup compare and update policy stay in branch_predictor.

Test Plan:
- Reset then sweep: assert rst_n for 1 cycle with enable=1. Expect ready=0 for exactly 64 cycles, then 1. Every lookup during the sweep returns pred_taken=0, pred_target=if_pc+4.
- Allocate and predict: update pc=0x40, taken, target=0x100. Next cycle, lookup 0x40 gives pred_hit=1, pred_taken=1, pred_target=0x100. Lookup 0x44 gives pred_hit=0.
- Hysteresis: from ctr=2, apply one not-taken update. Expect ctr=1 and pred_taken=0 with pred_hit=1. A further 3 not-taken updates keep ctr=0 (no wrap). Four taken updates saturate at 3.
- Aliasing: pc=0x40 and pc=0x140 share index 16 with different tags. A taken update of 0x140 replaces the entry; a lookup of 0x40 then misses.
- Collision and enable: a lookup and an update on the same index in the same cycle returns the old entry. Holding enable=0 mid-sweep freezes the sweep index. rst_n mid-update discards the update and restarts INIT.
- With BP_STATS_EN: 10 updates, 3 with upd_mispredict=1. Expect stat_updates=10, stat_mispredicts=3.
